// File: rtl/dmem_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a single-port 256x8 data memory.
// CPU has priority; a DMA request starved for STARVE_LIMIT CPU grants is forced through once.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_gnt,
    output logic [7:0] cpu_rdata,
    output logic       cpu_rvalid,
    input  logic       dma_req,
    input  logic       dma_we,
    input  logic [7:0] dma_addr,
    input  logic [7:0] dma_wdata,
    output logic       dma_gnt,
    output logic [7:0] dma_rdata,
    output logic       dma_rvalid,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    input  logic [7:0] mem_rdata
);

    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    localparam logic [0:0] CPU_PRI   = 1'b0;
    localparam logic [0:0] DMA_FORCE = 1'b1;

    logic [0:0]       mode;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!rst) begin
            if (mode == DMA_FORCE) begin
                dma_gnt = dma_req;
                cpu_gnt = cpu_req && !dma_req;
            end else begin
                cpu_gnt = cpu_req;
                dma_gnt = dma_req && !cpu_req;
            end
        end
    end

    // With no grant the CPU fields are presented, but the write strobe stays low.
    always_comb begin
        if (dma_gnt) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we;
        end else begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_gnt && cpu_we;
        end
    end

    // Counter saturates at LIMIT; it never exceeds it, so != is a safe bound test.
    always_comb begin
        cnt_next = starve_cnt;
        if (dma_gnt || !dma_req)
            cnt_next = '0;
        else if (cpu_gnt && starve_cnt != LIMIT)
            cnt_next = starve_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode       <= CPU_PRI;
            starve_cnt <= '0;
            cpu_rdata  <= 8'h00;
            cpu_rvalid <= 1'b0;
            dma_rdata  <= 8'h00;
            dma_rvalid <= 1'b0;
        end else begin
            starve_cnt <= cnt_next;
            case (mode)
                CPU_PRI:   if (dma_req && !dma_gnt && cnt_next == LIMIT) mode <= DMA_FORCE;
                DMA_FORCE: if (dma_gnt || !dma_req) mode <= CPU_PRI;
                default:   mode <= CPU_PRI;
            endcase
            cpu_rvalid <= cpu_gnt && !cpu_we;
            dma_rvalid <= dma_gnt && !dma_we;
            if (cpu_gnt && !cpu_we) cpu_rdata <= mem_rdata;
            if (dma_gnt && !dma_we) dma_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic checked against
// a transaction-level model (grant rule, starvation count, reference memory).
module tb_dmem_arbiter;

    localparam int LIM = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_we, dma_req, dma_we;
    logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic       cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_we;
    logic [7:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;

    logic       z_cg, z_crv, z_dg, z_drv, z_mwe;
    logic [7:0] z_crd, z_drd, z_ma, z_mwd;
    logic [7:0] zero8 = 8'h00;

    logic [7:0] tb_mem [256];

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(LIM)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Alternating-arbitration instance; only its grants are of interest.
    dmem_arbiter #(.STARVE_LIMIT(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(z_cg), .cpu_rdata(z_crd), .cpu_rvalid(z_crv),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(z_dg), .dma_rdata(z_drd), .dma_rvalid(z_drv),
        .mem_addr(z_ma), .mem_wdata(z_mwd), .mem_we(z_mwe), .mem_rdata(zero8)
    );

    assign mem_rdata = tb_mem[mem_addr];
    always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] ref_mem [256];
    int  m_wait,  m0_wait;
    bit  m_force, m0_force;
    bit  regs_known = 1'b0;
    logic [7:0] e_crd, e_drd;
    bit  e_crv, e_drv;
    bit  s_cg, s_dg, s_we, s0_cg, s0_dg;

    task automatic mdl_gnt(input bit r, input bit f, input bit cr, input bit dr,
                           output bit c, output bit d);
        c = 1'b0;
        d = 1'b0;
        if (!r) begin
            if (f && dr)  d = 1'b1;
            else if (cr)  c = 1'b1;
            else if (dr)  d = 1'b1;
        end
    endtask

    task automatic mdl_starve(input int lim, input bit r, input bit c, input bit d, input bit dr,
                              inout int w, inout bit f);
        if (r || d || !dr) begin
            w = 0;
            f = 1'b0;
        end else if (c) begin
            if (w < lim) w++;
            if (w == lim) f = 1'b1;
        end
    endtask

    // Drive one cycle, check everything at the falling edge, advance the model over the edge.
    task automatic cyc(input bit r,
                       input bit cr, input bit cw, input logic [7:0] ca, input logic [7:0] cd,
                       input bit dr, input bit dw, input logic [7:0] da, input logic [7:0] dd);
        bit ec, ed, ec0, ed0;
        rst = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
        @(negedge clk);
        mdl_gnt(r, m_force, cr, dr, ec, ed);
        mdl_gnt(r, m0_force, cr, dr, ec0, ed0);
        s_cg = cpu_gnt; s_dg = dma_gnt; s_we = mem_we; s0_cg = z_cg; s0_dg = z_dg;
        chk("cpu_gnt", {7'd0, cpu_gnt}, {7'd0, ec});
        chk("dma_gnt", {7'd0, dma_gnt}, {7'd0, ed});
        chk("mem_we", {7'd0, mem_we}, {7'd0, ed ? dw : (ec && cw)});
        chk("mem_addr", mem_addr, ed ? da : ca);
        chk("mem_wdata", mem_wdata, ed ? dd : cd);
        chk("l0_cpu_gnt", {7'd0, z_cg}, {7'd0, ec0});
        chk("l0_dma_gnt", {7'd0, z_dg}, {7'd0, ed0});
        if (regs_known) begin
            chk("cpu_rvalid", {7'd0, cpu_rvalid}, {7'd0, e_crv});
            chk("dma_rvalid", {7'd0, dma_rvalid}, {7'd0, e_drv});
            chk("cpu_rdata", cpu_rdata, e_crd);
            chk("dma_rdata", dma_rdata, e_drd);
        end
        if (r) begin
            e_crd = 8'h00; e_drd = 8'h00; e_crv = 1'b0; e_drv = 1'b0;
            regs_known = 1'b1;
        end else begin
            e_crv = ec && !cw;
            e_drv = ed && !dw;
            if (e_crv) e_crd = ref_mem[ca];
            if (e_drv) e_drd = ref_mem[da];
            if (ec && cw) ref_mem[ca] = cd;
            if (ed && dw) ref_mem[da] = dd;
        end
        mdl_starve(LIM, r, ec, ed, dr, m_wait, m_force);
        mdl_starve(0, r, ec0, ed0, dr, m0_wait, m0_force);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    bit         cp, dp, cpw, dpw;
    logic [7:0] cpa, cpd, dpa, dpd;

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = 8'($urandom);
            ref_mem[i] = tb_mem[i];
        end
        m_wait = 0; m_force = 1'b0; m0_wait = 0; m0_force = 1'b0;
        e_crd = 8'h00; e_drd = 8'h00; e_crv = 1'b0; e_drv = 1'b0;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 8'h00; dma_wdata = 8'h00;
        #1;

        // Reset with both ports requesting stores
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 8'h40, 8'hFF, 1'b1, 1'b1, 8'h41, 8'hEE);
            chk("rst_gnt", {6'd0, s_cg, s_dg}, 8'h00);
            chk("rst_mem_we", {7'd0, s_we}, 8'h00);
        end
        chk("rst_outs", cpu_rdata | dma_rdata | {6'd0, cpu_rvalid, dma_rvalid}, 8'h00);

        // Solo CPU store then load, first grant right after reset
        cyc(1'b0, 1'b1, 1'b1, 8'h10, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("solo_st_gnt", {7'd0, s_cg}, 8'h01);
        cyc(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("solo_ld_gnt", {7'd0, s_cg}, 8'h01);
        chk("solo_rvalid", {7'd0, cpu_rvalid}, 8'h01);
        chk("solo_rdata", cpu_rdata, 8'h5A);
        idle();
        chk("solo_rvalid_pulse", {7'd0, cpu_rvalid}, 8'h00);
        chk("solo_rdata_hold", cpu_rdata, 8'h5A);

        // Continuous contention: D every 5th cycle, and alternation for limit 0
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'(i), 8'h00, 1'b1, 1'b0, 8'(i + 100), 8'h00);
            chk("cont_dma_gnt", {7'd0, s_dg}, (i % 5 == 4) ? 8'h01 : 8'h00);
            chk("alt_dma_gnt", {7'd0, s0_dg}, (i % 2 == 1) ? 8'h01 : 8'h00);
        end

        // Withdrawal after two waits restarts the full count
        do_reset();
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b1, 8'h50, 8'h33);
        cyc(1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b1, 8'h50, 8'h33);
            chk("wd_dma_gnt", {7'd0, s_dg}, (i == 4) ? 8'h01 : 8'h00);
        end

        // Same-address CPU load vs DMA store
        do_reset();
        cyc(1'b0, 1'b1, 1'b1, 8'h20, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b1, 8'h20, 8'h77);
        chk("hz_cpu_first", {7'd0, s_cg}, 8'h01);
        chk("hz_old_value", cpu_rdata, 8'h11);
        cyc(1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 1'b1, 1'b1, 8'h20, 8'h77);
        chk("hz_dma_next", {7'd0, s_dg}, 8'h01);
        cyc(1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("hz_new_value", cpu_rdata, 8'h77);

        // Reset aborts a DMA store
        cyc(1'b0, 1'b1, 1'b1, 8'h30, 8'h99, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h30, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h30, 8'hAB);
        chk("mr_mem_kept", tb_mem[8'h30], 8'h99);
        chk("mr_dma_rvalid", {7'd0, dma_rvalid}, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b1, 8'h30, 8'hAB);
        chk("mr_cpu_pri", {7'd0, s_cg}, 8'h01);
        chk("mr_read", cpu_rdata, 8'h99);

        // Random traffic: requesters hold until granted; DMA may withdraw
        cp = 1'b0; dp = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if (!cp && $urandom_range(0, 3) != 0) begin
                cp = 1'b1; cpw = 1'($urandom); cpa = 8'($urandom_range(0, 15)); cpd = 8'($urandom);
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1'b1; dpw = 1'($urandom); dpa = 8'($urandom_range(0, 15)); dpd = 8'($urandom);
            end else if (dp && $urandom_range(0, 15) == 0) begin
                dp = 1'b0;
            end
            cyc(($urandom_range(0, 199) == 0), cp, cpw, cpa, cpd, dp, dpw, dpa, dpd);
            if (s_cg) cp = 1'b0;
            if (s_dg) dp = 1'b0;
        end
        for (int i = 0; i < 16; i++) chk("final_mem", tb_mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: the maximum number of consecutive CPU grants allowed while a DMA request waits.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cpu_req  input  1  CPU requests one data-memory access this cycle.
REQ-005 cpu_we  input  1  1 = store, 0 = load.
REQ-006 cpu_addr  input  8  CPU byte address.
REQ-007 cpu_wdata  input  8  CPU store data.
REQ-008 cpu_gnt  output  1  CPU access is accepted at this rising edge.
REQ-009 cpu_rdata  output  8  registered load data for the CPU.
REQ-010 cpu_rvalid  output  1  one-cycle pulse; cpu_rdata is valid.
REQ-011 dma_req, dma_we, dma_addr[7:0], dma_wdata[7:0]  input  these have the same meaning as the CPU inputs, for the DMA/loader port.
REQ-012 dma_gnt  output  1; dma_rdata  output  8; dma_rvalid  output  1  these have the same meaning as the CPU outputs.
REQ-013 mem_addr  output  8  address to the 256x8 data memory.
REQ-014 mem_wdata  output  8  write data to the data memory.
REQ-015 mem_we  output  1  write strobe; the memory writes at the rising edge when this is 1.
REQ-016 mem_rdata  input  8  combinational read data for mem_addr.

Function
REQ-017 Grant is combinational from the current-cycle requests and the registered state; at most one of cpu_gnt/dma_gnt is ever 1.
REQ-018 An access completes at a rising edge where req && gnt; an ungranted requester holds req, we, addr and wdata stable until granted.
REQ-019 Mode CPU_PRI: cpu_req wins; dma_gnt = dma_req && !cpu_req.
REQ-020 Mode DMA_FORCE: dma_req wins; cpu_gnt = cpu_req && !dma_req.
REQ-021 starve_cnt (width ceil(log2(STARVE_LIMIT+1))) increments on each edge with cpu_gnt && dma_req, saturating at STARVE_LIMIT.
REQ-022 starve_cnt clears on any edge where dma_gnt = 1 or dma_req = 0.
REQ-023 CPU_PRI -> DMA_FORCE on the edge where starve_cnt reaches STARVE_LIMIT.
REQ-024 DMA_FORCE -> CPU_PRI on the edge after exactly one DMA grant, or when dma_req = 0 (the request was withdrawn); at most one forced DMA access per starvation episode.
REQ-025 Memory outputs follow the granted port: mem_addr/mem_wdata come from the granted port; mem_we = granted port's we.
REQ-026 With no grant: mem_we = 0; mem_addr = cpu_addr; mem_wdata = cpu_wdata.
REQ-027 Load latency is one cycle: on a granted load edge, mem_rdata is captured into the port's rdata register, and rvalid = 1 for the following cycle only.
REQ-028 rdata holds its value until the next load for that port; stores do not change rdata or rvalid.
REQ-029 Back-to-back grants are supported every cycle; throughput is one access per cycle.
REQ-030 If a store and a load both target address A in consecutive cycles, the load returns the stored value; the memory write-at-edge ordering provides this.
REQ-031 With STARVE_LIMIT = 0, a pending DMA request is forced after zero CPU grants, i.e. the ports alternate.

Reset
REQ-032 While rst = 1: cpu_gnt = dma_gnt = 0 and mem_we = 0, regardless of requests.
REQ-033 While rst = 1: cpu_rdata = dma_rdata = 8'h00; cpu_rvalid = dma_rvalid = 0; starve_cnt = 0; mode = CPU_PRI.
REQ-034 Reset asserted mid-access aborts that access: no write occurs, and no rvalid appears after reset.
REQ-035 The first grant is possible in the first cycle with rst = 0.

Verification
REQ-036 Reset: hold rst = 1 with cpu_req = dma_req = 1 and we = 1 -> no grants, mem_we = 0, all outputs at 0.
REQ-037 Solo CPU: store 8'h5A to 8'h10, then load 8'h10 -> cpu_gnt on both cycles; cpu_rvalid = 1 one cycle after the load; cpu_rdata = 8'h5A.
REQ-038 Contention, STARVE_LIMIT = 4: cpu_req and dma_req held high continuously -> grant pattern C,C,C,C,D,C,C,C,C,D,... ; dma_gnt never absent for more than 4 cycles.
REQ-039 Withdrawal: DMA waits 2 cycles, then drops dma_req -> starve_cnt returns to 0; a later DMA request waits the full 4 CPU grants again.
REQ-040 Simultaneous load and store: CPU loads 8'h20 while DMA stores 8'h77 to 8'h20 -> CPU wins first; the CPU load returns the old value; the DMA store is granted the next cycle (cpu_req dropped); a following CPU load returns 8'h77.
REQ-041 Mid-access reset: assert rst on the same edge as a granted DMA store to 8'h30 -> memory at 8'h30 is unchanged; dma_rvalid = 0; mode = CPU_PRI after reset.
